pcie_tx_mux: RTL

//  Transmit-side merge for the PCIE transaction path, the inverse of the 1-to-4 VC split.

---
 rtl/pcie_tx_mux_pkg.sv | 29 ++
 rtl/pcie_tx_mux_fifo.sv | 49 ++++
 rtl/pcie_tx_mux.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pcie_tx_mux_pkg.sv
// Shared definitions for the PCIe transmit merge: FSM encoding, counter
// layout and the round-robin lane picker used by the arbiter.
package pcie_tx_mux_pkg;

  localparam int NUM_LANES   = 4;
  localparam int DEF_CNT_W   = 5;
  // Counters 0..3 track grants per lane, counter 4 tracks output pops.
  localparam int CNT_IDX_POP = NUM_LANES;
  localparam int NUM_CNT     = NUM_LANES + 1;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // Returns {found, lane}: first requesting lane at or after 'start',
  // wrapping around. Scanning downwards lets the nearest lane win last.
  function automatic logic [2:0] rr_pick(input logic [NUM_LANES-1:0] req,
                                         input logic [1:0] start);
    logic [1:0] lane;
    rr_pick = 3'b000;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      lane = start + 2'(k);
      if (req[lane]) rr_pick = {1'b1, lane};
    end
  endfunction

endpackage

// File: rtl/pcie_tx_mux_fifo.sv
// Synchronous FIFO with occupancy count. The head word is presented
// combinationally so the arbiter can forward it on the same edge it pops.
// Pushes on a full FIFO are dropped even if a pop happens that cycle.
module pcie_tx_mux_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && (count_reg != CW'(DEPTH));
  assign pop_ok  = pop && (count_reg != '0);
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage array, no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  // Pointer and occupancy bookkeeping; depth is a power of 2 so pointers wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/pcie_tx_mux.sv
// Transmit-side merge: four source lanes feed small input FIFOs, a
// round-robin arbiter moves one word per cycle into a shared output FIFO,
// throttled by a low/high occupancy hysteresis. Per-source transfer
// counters are readable through req/idx.
module pcie_tx_mux
  import pcie_tx_mux_pkg::*;
#(
  parameter int TAMANO_DATOS = 12,
  parameter int UMBRALES_L_H = 8,
  parameter int IN_DEPTH     = 4,
  parameter int OUT_DEPTH    = 8,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRALES_L_H-1:0] umbral_L,
  input  logic [UMBRALES_L_H-1:0] umbral_H,
  input  logic [NUM_LANES-1:0]    push_in,
  input  logic [TAMANO_DATOS-1:0] data_in0,
  input  logic [TAMANO_DATOS-1:0] data_in1,
  input  logic [TAMANO_DATOS-1:0] data_in2,
  input  logic [TAMANO_DATOS-1:0] data_in3,
  input  logic                    pop_out,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic                    valid_out,
  output logic                    empty_out,
  output logic                    pause,
  output logic [NUM_LANES-1:0]    full_in,
  output logic [NUM_LANES-1:0]    overflow_err,
  input  logic                    req,
  input  logic [2:0]              idx,
  output logic [CNT_W-1:0]        cnt_out,
  output logic                    cnt_valid
);

  localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
  localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

  state_t                  state_reg, state_next;
  logic [TAMANO_DATOS-1:0] lane_din   [NUM_LANES];
  logic [TAMANO_DATOS-1:0] lane_head  [NUM_LANES];
  logic [IN_CW-1:0]        lane_count [NUM_LANES];
  logic [NUM_LANES-1:0]    lane_empty;
  logic [NUM_LANES-1:0]    lane_full;
  logic [NUM_LANES-1:0]    lane_pop;
  logic [TAMANO_DATOS-1:0] out_head;
  logic [OUT_CW-1:0]       out_count;
  logic [OUT_CW-1:0]       out_count_next;
  logic [UMBRALES_L_H-1:0] out_count_ext;
  logic                    out_empty;
  logic                    out_pop_ok;
  logic                    grant;
  logic [2:0]              pick;
  logic [1:0]              rr_ptr_reg;
  logic                    pause_reg, pause_next;
  logic [UMBRALES_L_H-1:0] umbral_l_reg, umbral_h_reg;
  logic [NUM_LANES-1:0]    overflow_reg;
  logic [TAMANO_DATOS-1:0] data_out_reg;
  logic                    valid_out_reg;
  logic [CNT_W-1:0]        cnt_reg [NUM_CNT];
  logic [NUM_CNT-1:0]      cnt_inc;
  logic [CNT_W-1:0]        cnt_sel;
  logic [CNT_W-1:0]        cnt_out_reg;
  logic                    cnt_valid_reg;

  assign lane_din[0] = data_in0;
  assign lane_din[1] = data_in1;
  assign lane_din[2] = data_in2;
  assign lane_din[3] = data_in3;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      pcie_tx_mux_fifo #(
        .W     (TAMANO_DATOS),
        .DEPTH (IN_DEPTH)
      ) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_in[gi]),
        .pop   (lane_pop[gi]),
        .din   (lane_din[gi]),
        .head  (lane_head[gi]),
        .count (lane_count[gi])
      );
      assign lane_empty[gi] = (lane_count[gi] == '0);
      assign lane_full[gi]  = (lane_count[gi] == IN_CW'(IN_DEPTH));
    end
  endgenerate

  pcie_tx_mux_fifo #(
    .W     (TAMANO_DATOS),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (grant),
    .pop   (out_pop_ok),
    .din   (lane_head[pick[1:0]]),
    .head  (out_head),
    .count (out_count)
  );

  assign out_empty      = (out_count == '0);
  assign out_pop_ok     = pop_out && !out_empty;
  assign out_count_next = out_count + OUT_CW'(grant) - OUT_CW'(out_pop_ok);
  assign out_count_ext  = UMBRALES_L_H'(out_count_next);
  assign cnt_inc        = {out_pop_ok, lane_pop};

  // Round-robin grant: only in ACTIVE, not paused, and output has room.
  always_comb begin
    pick     = rr_pick(~lane_empty, rr_ptr_reg);
    grant    = (state_reg == ST_ACTIVE) && !pause_reg &&
               (out_count < OUT_CW'(OUT_DEPTH)) && pick[2];
    lane_pop = '0;
    if (grant) lane_pop[pick[1:0]] = 1'b1;
  end

  // Next-state logic; init always wins and sends the FSM back to INIT.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT:   if (!init) state_next = ST_IDLE;
      ST_IDLE:   if (init) state_next = ST_INIT;
                 else if (lane_empty != '1) state_next = ST_ACTIVE;
      ST_ACTIVE: if (init) state_next = ST_INIT;
                 else if (lane_empty == '1) state_next = ST_IDLE;
      default:   state_next = ST_INIT;
    endcase
  end

  // Hysteresis on the post-edge occupancy; set has priority over clear.
  always_comb begin
    pause_next = pause_reg;
    if (out_count_ext >= umbral_h_reg)      pause_next = 1'b1;
    else if (out_count_ext <= umbral_l_reg) pause_next = 1'b0;
  end

  // Counter read mux; indices past the last counter read as zero.
  always_comb begin
    cnt_sel = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (idx == 3'(k)) cnt_sel = cnt_reg[k];
    end
  end

  // FSM state, threshold latch, pause flag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_INIT;
      umbral_l_reg <= '0;
      umbral_h_reg <= UMBRALES_L_H'(OUT_DEPTH);
      pause_reg    <= 1'b0;
      rr_ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pause_reg <= pause_next;
      if (state_reg == ST_INIT && init) begin
        umbral_l_reg <= umbral_L;
        umbral_h_reg <= umbral_H;
      end
      if (grant) rr_ptr_reg <= pick[1:0] + 2'd1;
    end
  end

  // Output data register and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_reg  <= '0;
      valid_out_reg <= 1'b0;
      overflow_reg  <= '0;
    end else begin
      valid_out_reg <= out_pop_ok;
      if (out_pop_ok) data_out_reg <= out_head;
      overflow_reg <= overflow_reg | (push_in & lane_full);
    end
  end

  // Transfer counters (wrapping) and the registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CNT; k++) cnt_reg[k] <= '0;
      cnt_out_reg   <= '0;
      cnt_valid_reg <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CNT; k++) begin
        if (cnt_inc[k]) cnt_reg[k] <= cnt_reg[k] + CNT_W'(1);
      end
      cnt_valid_reg <= req;
      if (req) cnt_out_reg <= cnt_sel;
    end
  end

  assign data_out     = data_out_reg;
  assign valid_out    = valid_out_reg;
  assign empty_out    = out_empty;
  assign pause        = pause_reg;
  assign full_in      = lane_full;
  assign overflow_err = overflow_reg;
  assign cnt_out      = cnt_out_reg;
  assign cnt_valid    = cnt_valid_reg;

endmodule
